data_mem_responder: RTL

Multi-cycle data-memory responder for the MIPS datapath's load/store port. It accepts one word-sized read or write request per transaction over a valid/ready handshake and inserts a fixed number of wait cycles. It returns read data, or a write acknowledge, over a second valid/ready handshake. It replaces the combinational data memory when the datapath moves to a stalled, multi-cycle memory interface; misaligned and out-of-range accesses are flagged instead of silently aliased.

---
 rtl/data_mem_responder.sv | 97 +++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Multi-cycle word data memory for the load/store port: one request at a time, LATENCY wait cycles,
// response held until rsp_ready; misaligned or out-of-range accesses return rsp_err with no store.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        write_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] index;
  logic          access_err;
  logic          do_access;

  assign index      = addr_q[AW+1:2];
  assign access_err = (addr_q[1:0] != 2'b00) || (addr_q[31:AW+2] != '0);
  assign do_access  = (state == BUSY) && (cnt == 4'd0);

  // Storage has no reset; reset forces IDLE asynchronously, so a pending store never lands.
  always_ff @(posedge clk) begin
    if (do_access && write_q && !access_err) begin
      mem[index] <= wdata_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      write_q   <= 1'b0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            write_q   <= req_write;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            cnt       <= 4'(LATENCY - 1);
            req_ready <= 1'b0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == 4'd0) begin
            rsp_valid <= 1'b1;
            rsp_err   <= access_err;
            rsp_rdata <= (write_q || access_err) ? 32'd0 : mem[index];
            state     <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
